// File: rtl/inst_fetcher_if.sv
// Fetch-side bus bundle: instruction cache lookup/update, memory word fetch,
// decoder hand-off and back-end redirect.
interface inst_fetcher_if;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_data;
  logic        cache_upd;
  logic [31:0] cache_upd_addr;
  logic [31:0] cache_upd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        jump_en;
  logic [31:0] jump_pc;

  modport master (
    output cache_addr, cache_upd, cache_upd_addr, cache_upd_data,
           mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  cache_hit, cache_data, mem_done, mem_data, dec_ready, jump_en, jump_pc
  );

  modport slave (
    input  cache_addr, cache_upd, cache_upd_addr, cache_upd_data,
           mem_req, mem_addr, inst_valid, inst, inst_pc,
    output cache_hit, cache_data, mem_done, mem_data, dec_ready, jump_en, jump_pc
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher: looks up pc in the I-cache, refills misses from memory
// through the cache, and hands one instruction per cycle to the decoder.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  inst_fetcher_if.master bus
);
  typedef enum logic {FETCH, MISS_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        inst_valid, inst_valid_nxt;
  logic [31:0] inst, inst_nxt;
  logic [31:0] inst_pc, inst_pc_nxt;
  logic        mem_req, mem_req_nxt;
  logic [31:0] mem_addr, mem_addr_nxt;
  logic        cache_upd, cache_upd_nxt;
  logic [31:0] upd_addr, upd_addr_nxt;
  logic [31:0] upd_data, upd_data_nxt;
  logic        slot_free;
  logic        upd_pending;

  assign slot_free   = !inst_valid || bus.dec_ready;
  // The refill for pc is written at the end of this cycle; don't re-request it.
  assign upd_pending = cache_upd && (upd_addr == pc);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      cache_upd  <= 1'b0;
      upd_addr   <= '0;
      upd_data   <= '0;
    end else if (rdy_in) begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst_valid <= inst_valid_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      cache_upd  <= cache_upd_nxt;
      upd_addr   <= upd_addr_nxt;
      upd_data   <= upd_data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_valid_nxt = inst_valid;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    cache_upd_nxt  = 1'b0;
    upd_addr_nxt   = upd_addr;
    upd_data_nxt   = upd_data;

    // Refill completion is independent of redirects: the data is valid for mem_addr.
    if (state == MISS_WAIT && bus.mem_done) begin
      cache_upd_nxt = 1'b1;
      upd_addr_nxt  = mem_addr;
      upd_data_nxt  = bus.mem_data;
      mem_req_nxt   = 1'b0;
      state_nxt     = FETCH;
    end

    if (bus.jump_en) begin
      pc_nxt         = bus.jump_pc;
      inst_valid_nxt = 1'b0;
    end else begin
      if (bus.dec_ready) inst_valid_nxt = 1'b0;
      if (state == FETCH) begin
        if (bus.cache_hit) begin
          if (slot_free) begin
            inst_nxt       = bus.cache_data;
            inst_pc_nxt    = pc;
            inst_valid_nxt = 1'b1;
            pc_nxt         = pc + 32'd4;
          end
        end else if (!upd_pending) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = pc;
          state_nxt    = MISS_WAIT;
        end
      end
    end
  end

  assign bus.cache_addr     = pc;
  assign bus.cache_upd      = cache_upd;
  assign bus.cache_upd_addr = upd_addr;
  assign bus.cache_upd_data = upd_data;
  assign bus.mem_req        = mem_req;
  assign bus.mem_addr       = mem_addr;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = inst;
  assign bus.inst_pc        = inst_pc;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: direct-mapped cache model plus scripted memory responses.
module tb_inst_fetcher;
  logic clk_in, rst_in, rdy_in;
  inst_fetcher_if bus();

  inst_fetcher #(.RESET_PC(32'h0)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  // cache model: hit_all answers every address with ~addr; otherwise 64-entry direct map
  logic        hit_all, flush;
  bit          c_vld [64];
  logic [31:0] c_tag [64];
  logic [31:0] c_dat [64];
  logic [5:0]  cidx;
  int          upd_cnt = 0;

  assign cidx = bus.cache_addr[7:2];
  always_comb begin
    bus.cache_hit  = 1'b0;
    bus.cache_data = 32'h0;
    if (hit_all) begin
      bus.cache_hit  = 1'b1;
      bus.cache_data = ~bus.cache_addr;
    end else begin
      bus.cache_hit  = c_vld[cidx] && (c_tag[cidx] == bus.cache_addr);
      bus.cache_data = c_dat[cidx];
    end
  end

  always @(posedge clk_in) begin
    if (flush) begin
      for (int i = 0; i < 64; i++) c_vld[i] <= 1'b0;
    end else if (rdy_in && bus.cache_upd) begin
      c_vld[bus.cache_upd_addr[7:2]] <= 1'b1;
      c_tag[bus.cache_upd_addr[7:2]] <= bus.cache_upd_addr;
      c_dat[bus.cache_upd_addr[7:2]] <= bus.cache_upd_data;
      upd_cnt <= upd_cnt + 1;
    end
  end

  task automatic do_reset();
    rst_in = 1'b0; flush = 1'b1; rdy_in = 1'b1;
    bus.jump_en = 1'b0; bus.mem_done = 1'b0; bus.dec_ready = 1'b1;
    @(negedge clk_in); @(negedge clk_in);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.cache_addr !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", bus.cache_addr); end
    tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.inst_valid); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    tests++; if (bus.cache_upd !== 1'b0) begin fails++; $display("FAIL reset_upd got %b want 0", bus.cache_upd); end
    tests++; if (bus.inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h want 0", bus.inst); end
    tests++; if (bus.inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst_pc got %h want 0", bus.inst_pc); end
  endtask

  task automatic test_hit_stream();
    logic [31:0] a;
    do_reset();
    hit_all = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 32'(i * 4);
      exp_q.push_back('{pc: a, ins: ~a});
    end
    rst_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      tests++;
      if (bus.inst_valid !== 1'b1) begin
        fails++; $display("FAIL stream_valid cycle %0d got %b want 1", i, bus.inst_valid);
      end else begin
        e = exp_q.pop_front();
        if (bus.inst_pc !== e.pc || bus.inst !== e.ins) begin
          fails++; $display("FAIL stream_inst got pc %h inst %h want pc %h inst %h", bus.inst_pc, bus.inst, e.pc, e.ins);
        end
      end
    end
    exp_q.delete();
    tests++; if (bus.cache_addr !== 32'h20) begin fails++; $display("FAIL stream_pc got %h want 20", bus.cache_addr); end
  endtask

  task automatic test_freeze();
    // continues from the hit stream: inst_pc=0x1C held, pc=0x20
    rdy_in = 1'b0; bus.jump_en = 1'b1; bus.jump_pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      tests++;
      if (bus.inst_pc !== 32'h1C || bus.cache_addr !== 32'h20 || bus.inst_valid !== 1'b1) begin
        fails++; $display("FAIL freeze_hold got inst_pc %h pc %h valid %b want 1c 20 1", bus.inst_pc, bus.cache_addr, bus.inst_valid);
      end
    end
    rdy_in = 1'b1; bus.jump_en = 1'b0;
    @(negedge clk_in);
    tests++; if (bus.inst_pc !== 32'h20) begin fails++; $display("FAIL freeze_release got %h want 20", bus.inst_pc); end
  endtask

  task automatic test_back_pressure();
    bit found = 0;
    do_reset();
    hit_all = 1'b1; rst_in = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk_in);
      if (bus.inst_valid && bus.inst_pc == 32'h8) found = 1;
    end
    tests++; if (!found) begin fails++; $display("FAIL bp_reach got inst_pc %h want 8", bus.inst_pc); end
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      tests++;
      if (bus.inst_pc !== 32'h8 || bus.inst !== ~32'h8 || bus.cache_addr !== 32'hC || bus.inst_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold got inst_pc %h inst %h pc %h want 8 %h c", bus.inst_pc, bus.inst, bus.cache_addr, ~32'h8);
      end
    end
    bus.dec_ready = 1'b1;
    @(negedge clk_in);
    tests++; if (bus.inst_pc !== 32'hC || bus.inst_valid !== 1'b1) begin fails++; $display("FAIL bp_release got %h want c", bus.inst_pc); end
  endtask

  task automatic test_miss();
    int  up0;
    bit  found = 0;
    do_reset();
    hit_all = 1'b0; bus.jump_en = 1'b1; bus.jump_pc = 32'h100; rst_in = 1'b1;
    @(negedge clk_in);
    bus.jump_en = 1'b0;
    tests++; if (bus.cache_addr !== 32'h100 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL miss_jump got pc %h req %b want 100 0", bus.cache_addr, bus.mem_req); end
    up0 = upd_cnt;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      tests++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
        fails++; $display("FAIL miss_req cycle %0d got req %b addr %h want 1 100", k, bus.mem_req, bus.mem_addr);
      end
      if (k == 5) begin
        bus.mem_done = 1'b1; bus.mem_data = 32'h00A0_0093;
        exp_q.push_back('{pc: 32'h100, ins: 32'h00A0_0093});
      end
    end
    @(negedge clk_in);
    bus.mem_done = 1'b0;
    tests++;
    if (bus.cache_upd !== 1'b1 || bus.cache_upd_addr !== 32'h100 || bus.cache_upd_data !== 32'h00A0_0093 || bus.mem_req !== 1'b0) begin
      fails++; $display("FAIL miss_upd got upd %b addr %h data %h req %b want 1 100 00a00093 0",
                        bus.cache_upd, bus.cache_upd_addr, bus.cache_upd_data, bus.mem_req);
    end
    @(negedge clk_in);
    tests++; if (bus.cache_upd !== 1'b0) begin fails++; $display("FAIL miss_upd_pulse got %b want 0", bus.cache_upd); end
    for (int k = 0; k < 5 && !found; k++) begin
      if (bus.inst_valid) found = 1; else @(negedge clk_in);
    end
    if (!found && bus.inst_valid) found = 1;
    tests++;
    if (!found) begin
      fails++; $display("FAIL miss_deliver timeout got valid 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if (bus.inst_pc !== e.pc || bus.inst !== e.ins) begin
        fails++; $display("FAIL miss_deliver got pc %h inst %h want pc %h inst %h", bus.inst_pc, bus.inst, e.pc, e.ins);
      end
    end
    exp_q.delete();
    tests++; if (upd_cnt - up0 != 1) begin fails++; $display("FAIL miss_upd_count got %0d want 1", upd_cnt - up0); end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    hit_all = 1'b0; bus.jump_en = 1'b1; bus.jump_pc = 32'h40; rst_in = 1'b1;
    @(negedge clk_in);
    bus.jump_en = 1'b0;
    @(negedge clk_in);
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin fails++; $display("FAIL redir_req got %b %h want 1 40", bus.mem_req, bus.mem_addr); end
    bus.jump_en = 1'b1; bus.jump_pc = 32'h200;
    @(negedge clk_in);
    bus.jump_en = 1'b0;
    tests++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.cache_addr !== 32'h200) begin
      fails++; $display("FAIL redir_keep got req %b addr %h pc %h want 1 40 200", bus.mem_req, bus.mem_addr, bus.cache_addr);
    end
    bus.mem_done = 1'b1; bus.mem_data = 32'h1234_5678;
    @(negedge clk_in);
    bus.mem_done = 1'b0;
    tests++;
    if (bus.cache_upd !== 1'b1 || bus.cache_upd_addr !== 32'h40 || bus.cache_upd_data !== 32'h1234_5678) begin
      fails++; $display("FAIL redir_upd got %b %h %h want 1 40 12345678", bus.cache_upd, bus.cache_upd_addr, bus.cache_upd_data);
    end
    @(negedge clk_in);
    tests++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.inst_valid !== 1'b0) begin
      fails++; $display("FAIL redir_next got req %b addr %h valid %b want 1 200 0", bus.mem_req, bus.mem_addr, bus.inst_valid);
    end
    // redirect and refill completion land together
    bus.mem_done = 1'b1; bus.mem_data = 32'hCAFE_0013; bus.jump_en = 1'b1; bus.jump_pc = 32'h300;
    @(negedge clk_in);
    bus.mem_done = 1'b0; bus.jump_en = 1'b0;
    tests++;
    if (bus.cache_upd !== 1'b1 || bus.cache_upd_addr !== 32'h200 || bus.cache_upd_data !== 32'hCAFE_0013 ||
        bus.cache_addr !== 32'h300 || bus.inst_valid !== 1'b0) begin
      fails++; $display("FAIL redir_same_cycle got upd %b addr %h data %h pc %h valid %b want 1 200 cafe0013 300 0",
                        bus.cache_upd, bus.cache_upd_addr, bus.cache_upd_data, bus.cache_addr, bus.inst_valid);
    end
    @(negedge clk_in);
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin fails++; $display("FAIL redir_refetch got %b %h want 1 300", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_async_reset_wrap();
    do_reset();
    hit_all = 1'b1; rst_in = 1'b1;
    @(negedge clk_in);
    bus.dec_ready = 1'b0; hit_all = 1'b0;
    @(negedge clk_in);
    tests++; if (bus.mem_req !== 1'b1 || bus.inst_valid !== 1'b1) begin fails++; $display("FAIL areset_pre got req %b valid %b want 1 1", bus.mem_req, bus.inst_valid); end
    #2 rst_in = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin fails++; $display("FAIL areset_now got req %b valid %b want 0 0", bus.mem_req, bus.inst_valid); end
    @(negedge clk_in);
    hit_all = 1'b1; bus.dec_ready = 1'b1;
    bus.mem_done = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
    bus.jump_en = 1'b1; bus.jump_pc = 32'hFFFF_FFFC;
    rst_in = 1'b1;
    @(negedge clk_in);
    bus.mem_done = 1'b0; bus.jump_en = 1'b0;
    tests++;
    if (bus.cache_upd !== 1'b0 || bus.mem_req !== 1'b0 || bus.cache_addr !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL stray_done got upd %b req %b pc %h want 0 0 fffffffc", bus.cache_upd, bus.mem_req, bus.cache_addr);
    end
    @(negedge clk_in);
    tests++;
    if (bus.inst_pc !== 32'hFFFF_FFFC || bus.inst !== 32'h3 || bus.cache_addr !== 32'h0) begin
      fails++; $display("FAIL wrap got inst_pc %h inst %h pc %h want fffffffc 3 0", bus.inst_pc, bus.inst, bus.cache_addr);
    end
    @(negedge clk_in);
    tests++; if (bus.inst_pc !== 32'h0 || bus.inst_valid !== 1'b1) begin fails++; $display("FAIL wrap_next got %h want 0", bus.inst_pc); end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; hit_all = 1'b0; flush = 1'b1;
    bus.dec_ready = 1'b1; bus.jump_en = 1'b0; bus.jump_pc = 32'h0;
    bus.mem_done = 1'b0; bus.mem_data = 32'h0;
    test_reset();
    test_hit_stream();
    test_freeze();
    test_back_pressure();
    test_miss();
    test_redirect_miss();
    test_async_reset_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
